// File: rtl/pixel_arbiter.sv
// Two-port pixel arbiter: per-port 4-deep FIFOs drained round-robin into one registered VGA write.
// Define PIXEL_ARBITER_CLIP_EN to drop off-screen pixels (x>=160 or y>=120) before they are queued.
module pixel_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [2:0] a_colour,
  input  logic       a_wren,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [2:0] b_colour,
  input  logic       b_wren,
  output logic       a_ready,
  output logic       b_ready,
  output logic       a_ovf,
  output logic       b_ovf,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_wren
);

  localparam int unsigned Depth = 4;

  logic [22:0] mem_q [2][Depth];
  logic [1:0]  wptr_q [2];
  logic [1:0]  rptr_q [2];
  logic [2:0]  cnt_q  [2];
  logic [2:0]  cnt_d  [2];
  logic [1:0]  ovf_q;
  logic        last_grant_q;  // 0 = A granted last, 1 = B

  logic [22:0] in_data [2];
  logic [1:0]  in_wren, full, empty, clip, push, pop;
  logic        gnt_valid, gnt_sel;

  logic [9:0]  vga_x_q, vga_y_q;
  logic [2:0]  vga_colour_q;
  logic        vga_wren_q;

  always_comb begin
    in_data[0] = {a_x, a_y, a_colour};
    in_data[1] = {b_x, b_y, b_colour};
    in_wren    = {b_wren, a_wren};
    full       = '0;
    empty      = '0;
    clip       = '0;
    push       = '0;
    for (int p = 0; p < 2; p++) begin
      full[p]  = (cnt_q[p] == 3'd4);
      empty[p] = (cnt_q[p] == 3'd0);
`ifdef PIXEL_ARBITER_CLIP_EN
      clip[p]  = (in_data[p][22:13] >= 10'd160) || (in_data[p][12:3] >= 10'd120);
`else
      clip[p]  = 1'b0;
`endif
      push[p]  = in_wren[p] & ~clip[p] & ~full[p];
    end
    gnt_valid = ~(empty[0] & empty[1]);
    // Contested: the port not served last time; otherwise whichever is non-empty.
    if (!empty[0] && !empty[1]) gnt_sel = ~last_grant_q;
    else                        gnt_sel = empty[0];
    pop[0] = gnt_valid & ~gnt_sel;
    pop[1] = gnt_valid & gnt_sel;
    for (int p = 0; p < 2; p++) begin
      cnt_d[p] = cnt_q[p] + {2'b00, push[p]} - {2'b00, pop[p]};
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!reset && push[p]) mem_q[p][wptr_q[p]] <= in_data[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        wptr_q[p] <= 2'd0;
        rptr_q[p] <= 2'd0;
        cnt_q[p]  <= 3'd0;
      end
      ovf_q        <= 2'b00;
      last_grant_q <= 1'b1;
      vga_x_q      <= 10'd0;
      vga_y_q      <= 10'd0;
      vga_colour_q <= 3'd0;
      vga_wren_q   <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wptr_q[p] <= wptr_q[p] + 2'd1;
        if (pop[p])  rptr_q[p] <= rptr_q[p] + 2'd1;
        cnt_q[p] <= cnt_d[p];
      end
      // A strobe into a full FIFO overflows even if that FIFO pops this cycle.
      ovf_q      <= ovf_q | (in_wren & ~clip & full);
      vga_wren_q <= gnt_valid;
      if (gnt_valid) begin
        {vga_x_q, vga_y_q, vga_colour_q} <= mem_q[gnt_sel][rptr_q[gnt_sel]];
        last_grant_q                     <= gnt_sel;
      end
    end
  end

  assign a_ready    = ~full[0];
  assign b_ready    = ~full[1];
  assign a_ovf      = ovf_q[0];
  assign b_ovf      = ovf_q[1];
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_wren   = vga_wren_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Bench for pixel_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_pixel_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic [2:0] a_colour, b_colour;
  logic       a_wren, b_wren;
  logic       a_ready, b_ready, a_ovf, b_ovf;
  logic [9:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_wren;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one queue per port, round-robin pointer, sticky flags, output register.
  logic [22:0] mq_a[$];
  logic [22:0] mq_b[$];
  bit          m_last = 1'b1;
  bit          m_aovf = 1'b0;
  bit          m_bovf = 1'b0;
  logic [22:0] m_vga  = '0;
  bit          m_wren = 1'b0;

  pixel_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .a_x        (a_x),
    .a_y        (a_y),
    .a_colour   (a_colour),
    .a_wren     (a_wren),
    .b_x        (b_x),
    .b_y        (b_y),
    .b_colour   (b_colour),
    .b_wren     (b_wren),
    .a_ready    (a_ready),
    .b_ready    (b_ready),
    .a_ovf      (a_ovf),
    .b_ovf      (b_ovf),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_wren   (vga_wren)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] px(input int x, input int y, input int c);
    logic [9:0] xx, yy;
    logic [2:0] cc;
    xx = x[9:0];
    yy = y[9:0];
    cc = c[2:0];
    return {xx, yy, cc};
  endfunction

  function automatic bit clipped(input logic [22:0] d);
`ifdef PIXEL_ARBITER_CLIP_EN
    return (d[22:13] >= 10'd160) || (d[12:3] >= 10'd120);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [27:0] obs_vec();
    return {vga_wren, vga_x, vga_y, vga_colour, a_ready, b_ready, a_ovf, b_ovf};
  endfunction

  function automatic logic [27:0] exp_vec();
    return {m_wren, m_vga, 1'(mq_a.size() != 4), 1'(mq_b.size() != 4), m_aovf, m_bovf};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1 ns after it.
  task automatic cycle(input bit rst, input bit aw, input logic [22:0] ad,
                       input bit bw, input logic [22:0] bd);
    bit a_full, b_full;
    reset = rst;
    a_wren = aw;
    {a_x, a_y, a_colour} = ad;
    b_wren = bw;
    {b_x, b_y, b_colour} = bd;
    if (rst) begin
      mq_a.delete();
      mq_b.delete();
      m_last = 1'b1;
      m_aovf = 1'b0;
      m_bovf = 1'b0;
      m_vga  = '0;
      m_wren = 1'b0;
    end else begin
      a_full = (mq_a.size() == 4);
      b_full = (mq_b.size() == 4);
      if (mq_a.size() > 0 && (mq_b.size() == 0 || m_last)) begin
        m_vga = mq_a.pop_front();
        m_wren = 1'b1;
        m_last = 1'b0;
      end else if (mq_b.size() > 0) begin
        m_vga = mq_b.pop_front();
        m_wren = 1'b1;
        m_last = 1'b1;
      end else begin
        m_wren = 1'b0;
      end
      if (aw && !clipped(ad)) begin
        if (a_full) m_aovf = 1'b1;
        else mq_a.push_back(ad);
      end
      if (bw && !clipped(bd)) begin
        if (b_full) m_bovf = 1'b1;
        else mq_b.push_back(bd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, px(1, 1, 1), 1'b1, px(2, 2, 2));
    n_cmp++;
    if ({vga_wren, vga_x, vga_y, vga_colour, a_ovf, b_ovf} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {vga_wren, vga_x, vga_y, vga_colour, a_ovf, b_ovf});
    end
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 11", {a_ready, b_ready});
    end
    idle();
    n_cmp++;
    if (vga_wren !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_stale: vga_wren got %b want 0", vga_wren);
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, px(5, 64, 4), 1'b0, '0);
    n_cmp++;
    if (vga_wren !== 1'b0) begin
      n_err++;
      $display("FAIL single_push_edge: vga_wren got %b want 0", vga_wren);
    end
    idle();
    n_cmp++;
    if ({vga_wren, vga_x, vga_y, vga_colour} !== {1'b1, 10'd5, 10'd64, 3'd4}) begin
      n_err++;
      $display("FAIL single_out: got wren=%b x=%0d y=%0d c=%0d want 1/5/64/4",
               vga_wren, vga_x, vga_y, vga_colour);
    end
    idle();
    n_cmp++;
    if ({vga_wren, vga_x} !== {1'b0, 10'd5}) begin
      n_err++;
      $display("FAIL single_after: got wren=%b x=%0d want 0/5 (held)", vga_wren, vga_x);
    end
  endtask

  task automatic test_both_same_cycle();
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, px(1, 2, 3), 1'b1, px(7, 8, 1));
    idle();
    n_cmp++;
    if ({vga_wren, vga_x, vga_y, vga_colour} !== {1'b1, px(1, 2, 3)}) begin
      n_err++;
      $display("FAIL both_first_is_a: got %b %0d %0d %0d want 1 1 2 3",
               vga_wren, vga_x, vga_y, vga_colour);
    end
    idle();
    n_cmp++;
    if ({vga_wren, vga_x, vga_y, vga_colour} !== {1'b1, px(7, 8, 1)}) begin
      n_err++;
      $display("FAIL both_second_is_b: got %b %0d %0d %0d want 1 7 8 1",
               vga_wren, vga_x, vga_y, vga_colour);
    end
  endtask

  // Four writes per port back to back: output must interleave A,B,A,B,... with no overflow.
  task automatic test_alternate();
    logic [22:0] pa[4], pb[4], got[$], want[$];
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      pa[i] = px($urandom_range(159), $urandom_range(119), $urandom_range(7));
      pb[i] = px($urandom_range(159), $urandom_range(119), $urandom_range(7));
      want.push_back(pa[i]);
      want.push_back(pb[i]);
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 4) cycle(1'b0, 1'b1, pa[i], 1'b1, pb[i]);
      else idle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL alternate_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (vga_wren) got.push_back({vga_x, vga_y, vga_colour});
    end
    n_cmp++;
    if (got != want || a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL alternate_order: got %0d pixels ovf=%b%b want 8 pixels ABAB.. ovf=00",
               got.size(), a_ovf, b_ovf);
    end
  endtask

  // A writes 8 cycles, B the first 6: A fills during cycle 7, A pixel 8 is dropped.
  task automatic test_overflow();
    logic [22:0] pa[8], pb[6], got[$], want[$];
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 8; i++) pa[i] = px(i + 10, i + 20, i);
    for (int i = 0; i < 6; i++) pb[i] = px(i + 100, i + 50, 7 - i);
    for (int i = 0; i < 6; i++) begin
      want.push_back(pa[i]);
      want.push_back(pb[i]);
    end
    want.push_back(pa[6]);
    for (int i = 0; i < 20; i++) begin
      if (i < 8) cycle(1'b0, 1'b1, pa[i], i < 6, (i < 6) ? pb[i] : '0);
      else idle();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL overflow_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 6) begin
        n_cmp++;
        if ({a_ready, a_ovf} !== 2'b00) begin
          n_err++;
          $display("FAIL overflow_full: a_ready/a_ovf got %b%b want 00", a_ready, a_ovf);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({a_ovf, b_ovf} !== 2'b10) begin
          n_err++;
          $display("FAIL overflow_flags: a_ovf/b_ovf got %b%b want 10", a_ovf, b_ovf);
        end
      end
      if (vga_wren) got.push_back({vga_x, vga_y, vga_colour});
    end
    n_cmp++;
    if (got != want || a_ovf !== 1'b1 || b_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_sequence: got %0d pixels ovf=%b%b want 13 pixels ovf=10",
               got.size(), a_ovf, b_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, px(30 + i, 40, 2), 1'b1, px(60 + i, 70, 5));
    cycle(1'b1, 1'b1, px(99, 99, 1), 1'b1, px(98, 98, 1));
    n_cmp++;
    if ({vga_wren, a_ready, a_ovf} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_mid: wren/a_ready/a_ovf got %b%b%b want 010",
               vga_wren, a_ready, a_ovf);
    end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (vga_wren) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL reset_mid_stale: got %0d pixels out want 0", stale);
    end
  endtask

  task automatic test_clip();
    logic [22:0] got[$];
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, px(160, 10, 3), 1'b0, '0);
    cycle(1'b0, 1'b1, px(159, 119, 6), 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      idle();
      if (vga_wren) got.push_back({vga_x, vga_y, vga_colour});
    end
`ifdef PIXEL_ARBITER_CLIP_EN
    n_cmp++;
    if (got.size() != 1 || got[0] !== px(159, 119, 6) || a_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clip: got %0d pixels ovf=%b want only (159,119) ovf=0", got.size(), a_ovf);
    end
`else
    n_cmp++;
    if (got.size() != 1 || got[0] !== px(159, 119, 6) || vga_x !== 10'd159) begin
      n_err++;
      $display("FAIL noclip: got %0d pixels after latency, last x=%0d want 1 / 159",
               got.size(), vga_x);
    end
    n_cmp++;
    if (a_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL noclip_ovf: got %b want 0", a_ovf);
    end
`endif
  endtask

  // Random strobes over the full coordinate range, occasional reset, model-checked every cycle.
  task automatic test_random();
    bit aw, bw, rst;
    logic [22:0] ad, bd;
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      aw  = ($urandom_range(3) != 0);
      bw  = ($urandom_range(3) != 0);
      ad  = px($urandom_range(200), $urandom_range(150), $urandom_range(7));
      bd  = px($urandom_range(1023), $urandom_range(1023), $urandom_range(7));
      cycle(rst, aw, ad, bw, bd);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a_wren = 1'b0;
    b_wren = 1'b0;
    {a_x, a_y, a_colour} = '0;
    {b_x, b_y, b_colour} = '0;
    test_reset();
    test_single();
    test_both_same_cycle();
    test_alternate();
    test_overflow();
    test_reset_mid();
    test_clip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
